dmem_arbiter: RTL and testbench

Two-requester controller that shares the single-port, byte-addressed data memory between the CPU MEM-stage port (port 0) and a debug/loader port (port 1). It grants one requester at a time, using round-robin between the two ports. It sequences each access into a one-cycle memory strobe, captures read data, and returns a one-cycle response. It sits between the requesters and the data memory's `addr/Writedata/MemRead/MemWrite/Readdata` pins.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 15 +
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes, responses and memory pins of the data-memory arbiter.
// "master" is the side that owns the requesters and the memory array,
// "slave" is the arbiter itself.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0_valid_i;
  logic          req0_write_i;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_wdata_i;
  logic          req0_ready_o;
  logic          rsp0_valid_o;
  logic [DW-1:0] rsp0_rdata_o;
  logic          rsp0_err_o;

  logic          req1_valid_i;
  logic          req1_write_i;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_wdata_i;
  logic          req1_ready_o;
  logic          rsp1_valid_o;
  logic [DW-1:0] rsp1_rdata_o;
  logic          rsp1_err_o;

  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    output req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    output req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
    input  req1_ready_o, rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
    output mem_rdata_i
  );

  modport slave (
    input  req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
    output req0_ready_o, rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    input  req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
    output req1_ready_o, rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
    input  mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// port that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant, purely combinational.
  always_comb begin
    gnt = req;
    if (&req) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port byte-addressed data memory between the CPU port (0)
// and the debug/loader port (1). Each access takes IDLE -> ACCESS -> RESP,
// i.e. one accepted request every three cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  dmem_arbiter_if.slave bus
);

  // Highest legal word start address, one bit wider than the address so an
  // address near 2^AW cannot wrap into range.
  localparam logic [AW:0] LAST_WORD = (AW+1)'(MEM_BYTES - 4);

  state_t                 state;
  logic                   last_grant;
  logic                   gnt_idx;
  logic                   write_q;
  logic                   err_q;
  logic [AW-1:0]          addr_q;
  logic [DW-1:0]          wdata_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [1:0]             rsp_valid_q;
  logic [1:0]             rsp_err_q;
  logic [1:0][DW-1:0]     rsp_rdata_q;

  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   accept;
  logic                   sel_write;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wdata;
  logic                   oor;

  assign req = {bus.req1_valid_i, bus.req0_valid_i};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Ready is only offered in IDLE and never while reset is held, so nothing
  // can be accepted into a transaction that the reset edge would discard.
  assign accept           = rst_i && (state == IDLE) && (|req);
  assign bus.req0_ready_o = accept & gnt[PORT_CPU];
  assign bus.req1_ready_o = accept & gnt[PORT_DBG];

  // Payload of whichever port wins this cycle.
  assign sel_write = gnt[PORT_DBG] ? bus.req1_write_i : bus.req0_write_i;
  assign sel_addr  = gnt[PORT_DBG] ? bus.req1_addr_i  : bus.req0_addr_i;
  assign sel_wdata = gnt[PORT_DBG] ? bus.req1_wdata_i : bus.req0_wdata_i;
  assign oor       = {1'b0, sel_addr} > LAST_WORD;

  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_read_o   = mem_read_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.rsp0_valid_o = rsp_valid_q[PORT_CPU];
  assign bus.rsp1_valid_o = rsp_valid_q[PORT_DBG];
  assign bus.rsp0_err_o   = rsp_err_q[PORT_CPU];
  assign bus.rsp1_err_o   = rsp_err_q[PORT_DBG];
  assign bus.rsp0_rdata_o = rsp_rdata_q[PORT_CPU];
  assign bus.rsp1_rdata_o = rsp_rdata_q[PORT_DBG];

  // Access sequencer: grant and latch in IDLE, one-cycle strobe in ACCESS,
  // one-cycle response pulse in RESP. Strobes are low in IDLE and RESP, so
  // every load produces a fresh rising edge on the read strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt_idx     <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= ACCESS;
            gnt_idx     <= gnt[PORT_DBG];
            last_grant  <= gnt[PORT_DBG];
            write_q     <= sel_write;
            err_q       <= oor;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_read_q  <= !sel_write && !oor;
            mem_write_q <= sel_write && !oor;
          end
        end
        ACCESS: begin
          state                <= RESP;
          mem_read_q           <= 1'b0;
          mem_write_q          <= 1'b0;
          rsp_valid_q[gnt_idx] <= 1'b1;
          rsp_err_q[gnt_idx]   <= err_q;
          rsp_rdata_q[gnt_idx] <= (!write_q && !err_q) ? bus.mem_rdata_i : '0;
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= '0;
          rsp_err_q   <= '0;
          rsp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.MEM_BYTES(32), .AW(32), .DW(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // 32-byte memory, little-endian, not reset. Word @0 = A0A1A2A3, @4 = B0B1B2B3.
  logic [7:0] mem [0:31];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 32; k++) mem[k] <= 8'h00;
      mem[0] <= 8'hA3; mem[1] <= 8'hA2; mem[2] <= 8'hA1; mem[3] <= 8'hA0;
      mem[4] <= 8'hB3; mem[5] <= 8'hB2; mem[6] <= 8'hB1; mem[7] <= 8'hB0;
    end else if (bus.mem_write_o) begin
      for (int k = 0; k < 4; k++)
        mem[5'(bus.mem_addr_o[4:0] + 5'(k))] <= bus.mem_wdata_o[8*k +: 8];
    end
  end

  always_comb begin
    bus.mem_rdata_i = '0;
    if (bus.mem_read_o)
      for (int k = 0; k < 4; k++)
        bus.mem_rdata_i[8*k +: 8] = mem[5'(bus.mem_addr_o[4:0] + 5'(k))];
  end

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic vld, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1_valid_i = vld; bus.req1_write_i = wr;
      bus.req1_addr_i  = a;   bus.req1_wdata_i = d;
    end else begin
      bus.req0_valid_i = vld; bus.req0_write_i = wr;
      bus.req0_addr_i  = a;   bus.req0_wdata_i = d;
    end
  endtask

  // Called at a falling edge; samples ready 1 time unit later, bounded.
  task automatic wait_rdy(input logic [1:0] mask, output logic got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (|({bus.req1_ready_o, bus.req0_ready_o} & mask)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One isolated transaction: accept, strobe one cycle later, response two
  // cycles after accept, routed to the requesting port only.
  task automatic run_txn(input vec_t v, input string tag);
    logic got;
    logic strobe;
    @(negedge clk);
    drive(v.port, 1'b1, v.write, v.addr, v.wdata);
    wait_rdy(v.port ? 2'b10 : 2'b01, got);
    chk({tag, "_ready"}, 32'(got), 32'd1);
    if (!got) begin
      drive(v.port, 1'b0, 1'b0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, '0, '0);
    strobe = !v.exp_err;
    @(negedge clk);
    chk({tag, "_mwr"}, 32'(bus.mem_write_o), 32'(v.write && strobe));
    chk({tag, "_mrd"}, 32'(bus.mem_read_o), 32'(!v.write && strobe));
    if (strobe) chk({tag, "_maddr"}, bus.mem_addr_o, v.addr);
    @(negedge clk);
    chk({tag, "_rvld"}, {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o},
        v.port ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, v.port ? bus.rsp1_rdata_o : bus.rsp0_rdata_o, v.exp_rdata);
    chk({tag, "_rerr"}, 32'(v.port ? bus.rsp1_err_o : bus.rsp0_err_o), 32'(v.exp_err));
    chk({tag, "_strobe_low"}, {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
  endtask

  initial begin
    logic got;
    logic w;

    vecs[0]  = '{1'b0, 1'b1, 32'd8,          32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd8,          32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'd4,          32'hCAFEF00D, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd4,          32'h0,        32'hCAFEF00D, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd28,         32'h01020304, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd29,         32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'hFFFFFFFE,   32'hAAAAAAAA, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd28,         32'h0,        32'h01020304, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'd4,          32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'd1,          32'h11223344, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'd0,          32'h0,        32'h223344A3, 1'b0};

    // Reset held 3 cycles with both ports requesting loads @0 / @4.
    rst = 1'b0;
    init_mem = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      init_mem = 1'b0;
      chk("rst_ctrl", {24'd0, bus.req0_ready_o, bus.req1_ready_o, bus.rsp0_valid_o,
                       bus.rsp1_valid_o, bus.rsp0_err_o, bus.rsp1_err_o,
                       bus.mem_read_o, bus.mem_write_o}, 32'd0);
      chk("rst_data", bus.rsp0_rdata_o | bus.rsp1_rdata_o | bus.mem_addr_o | bus.mem_wdata_o,
          32'd0);
    end
    rst = 1'b1;

    // Contention: both valid continuously, grants must go 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++) begin
      wait_rdy(2'b11, got);
      chk("cont_ready", 32'(got), 32'd1);
      if (!got) break;
      chk("cont_onehot", 32'(bus.req0_ready_o & bus.req1_ready_o), 32'd0);
      w = bus.req1_ready_o;
      chk("cont_gnt", 32'(w), 32'(k % 2));
      @(posedge clk); #1;
      if (k == 5) begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      chk("cont_mrd", 32'(bus.mem_read_o), 32'd1);
      @(negedge clk);
      chk("cont_rvld", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, w ? 32'd2 : 32'd1);
      chk("cont_rdata", w ? bus.rsp1_rdata_o : bus.rsp0_rdata_o,
          w ? 32'hB0B1B2B3 : 32'hA0A1A2A3);
      chk("cont_mrd_gap", 32'(bus.mem_read_o), 32'd0);
      @(negedge clk);
    end

    // Single-port store/load, range errors and the unaligned byte-lane case.
    for (int i = 0; i < 11; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset lands on the edge that would enter RESP: no response may appear.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd8, 32'h0);
    wait_rdy(2'b01, got);
    chk("mid_ready", 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_mrd", 32'(bus.mem_read_o), 32'd1);
    @(negedge clk);
    chk("mid_no_rsp", {29'd0, bus.rsp1_valid_o, bus.rsp0_valid_o, bus.mem_read_o}, 32'd0);
    rst = 1'b1;
    run_txn('{1'b1, 1'b0, 32'd8, 32'h0, 32'hDEADBEEF, 1'b0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
